// File: rtl/ram2_pkg.sv
// ============================================================================
// Module : ram2_pkg
// Brief  : Shared RAM2 types and widths for the controller and the responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram2_pkg;

  localparam int RAM2_ADDR_W = 18;
  localparam int RAM2_DATA_W = 16;

  typedef enum logic [1:0] {
    RESP_IDLE      = 2'd0,
    RESP_RD_WAIT   = 2'd1,
    RESP_RD_DRIVE  = 2'd2,
    RESP_WR_ACTIVE = 2'd3
  } resp_state_t;

endpackage

`default_nettype wire

// File: rtl/ram2_resp_mem.sv
// ============================================================================
// Module : ram2_resp_mem
// Brief  : Single-port synchronous RAM, registered read, one write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram2_resp_mem
  import ram2_pkg::*;
#(
  parameter int DATA_W  = RAM2_DATA_W,
  parameter int DEPTH_W = 12
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [DEPTH_W-1:0] addr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic [DATA_W-1:0]  rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ram2_sram_responder.sv
// ============================================================================
// Module : ram2_sram_responder
// Brief  : Block-RAM stand-in for the RAM2 external SRAM pins.
//          Optional access counters enabled by RAM2_RESP_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram2_sram_responder
  import ram2_pkg::*;
#(
  parameter int ADDR_W   = RAM2_ADDR_W,
  parameter int DATA_W   = RAM2_DATA_W,
  parameter int DEPTH_W  = 12,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ram_addr_i,
  inout  wire  [DATA_W-1:0] ram_data_io,
  input  logic              ram_oe_i,
  input  logic              ram_we_i,
  input  logic              ram_en_i,
  output logic              busy_o,
  output logic              conflict_o
`ifdef RAM2_RESP_STATS_EN
  ,
  output logic [15:0]       rd_cnt_o,
  output logic [15:0]       wr_cnt_o
`endif
);

  localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

  logic [ADDR_W-1:0]  s_addr_q, s_addr_d;
  logic [DATA_W-1:0]  s_data_q, s_data_d;
  logic               s_oe_q, s_oe_d;
  logic               s_we_q, s_we_d;
  logic               s_en_q, s_en_d;

  resp_state_t        state_q, state_d;
  logic [3:0]         lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DEPTH_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               conflict_q, conflict_d;

  logic               commit;
  logic               both_low;
  logic               drive_en;
  logic [DEPTH_W-1:0] mem_addr;
  logic [DATA_W-1:0]  mem_rdata;

  always_comb begin
    s_addr_d = ram_addr_i;
    s_data_d = ram_data_io;
    s_oe_d   = ram_oe_i;
    s_we_d   = ram_we_i;
    s_en_d   = ram_en_i;
  end

  // Strobes reset to their inactive (high) level so nothing fires out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_addr_q <= '0;
      s_data_q <= '0;
      s_oe_q   <= 1'b1;
      s_we_q   <= 1'b1;
      s_en_q   <= 1'b1;
    end else begin
      s_addr_q <= s_addr_d;
      s_data_q <= s_data_d;
      s_oe_q   <= s_oe_d;
      s_we_q   <= s_we_d;
      s_en_q   <= s_en_d;
    end
  end

  assign both_low = ~s_oe_q & ~s_we_q & ~s_en_q;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    conflict_d = conflict_q | both_low;
    commit     = 1'b0;

    case (state_q)
      RESP_IDLE: begin
        if (!s_en_q && !s_we_q) begin
          state_d = RESP_WR_ACTIVE;
        end else if (!s_en_q && !s_oe_q) begin
          state_d   = RESP_RD_WAIT;
          lat_cnt_d = '0;
          rd_addr_d = s_addr_q;
        end
      end
      RESP_RD_WAIT: begin
        if (both_low) begin
          state_d = RESP_WR_ACTIVE;
        end else if (s_oe_q || s_en_q) begin
          state_d = RESP_IDLE;
        end else if (lat_cnt_q == LAT_LAST) begin
          state_d = RESP_RD_DRIVE;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      RESP_RD_DRIVE: begin
        if (both_low) begin
          state_d = RESP_WR_ACTIVE;
        end else if (s_oe_q || s_en_q) begin
          state_d = RESP_IDLE;
        end else if (s_addr_q != rd_addr_q) begin
          state_d   = RESP_RD_WAIT;
          lat_cnt_d = '0;
          rd_addr_d = s_addr_q;
        end
      end
      RESP_WR_ACTIVE: begin
        if (s_we_q || s_en_q) begin
          commit  = 1'b1;
          state_d = RESP_IDLE;
        end
      end
      default: state_d = RESP_IDLE;
    endcase

    // Only cycles sampled with WE and EN low are captured; the commit cycle
    // itself carries stale bus data and must not overwrite the last word.
    if (state_d == RESP_WR_ACTIVE) begin
      wr_addr_d = s_addr_q[DEPTH_W-1:0];
      wr_data_d = s_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESP_IDLE;
      lat_cnt_q  <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      conflict_q <= conflict_d;
    end
  end

  // The read address stays on the RAM through RD_WAIT and RD_DRIVE, so the
  // registered RAM output is valid on entry to RD_DRIVE and stays stable.
  assign mem_addr = commit ? wr_addr_q : rd_addr_q[DEPTH_W-1:0];

  ram2_resp_mem #(
    .DATA_W  (DATA_W),
    .DEPTH_W (DEPTH_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (commit),
    .addr_i  (mem_addr),
    .wdata_i (wr_data_q),
    .rdata_o (mem_rdata)
  );

  // Raw pins gate the driver so the bus releases combinationally; a raw WE
  // also releases it, since a write always wins over a read.
  assign drive_en    = (state_q == RESP_RD_DRIVE) & ~ram_oe_i & ~ram_en_i & ram_we_i;
  assign ram_data_io = drive_en ? mem_rdata : {DATA_W{1'bz}};

  assign busy_o     = (state_q != RESP_IDLE);
  assign conflict_o = conflict_q;

`ifdef RAM2_RESP_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if ((state_d == RESP_RD_DRIVE) && (state_q != RESP_RD_DRIVE)) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (commit) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram2_sram_responder.sv
// ============================================================================
// Module : tb_ram2_sram_responder
// Brief  : Self-checking bench for ram2_sram_responder against an array model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram2_sram_responder;

  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 16;
  localparam int DEPTH_W  = 12;
  localparam int READ_LAT = 2;
  localparam int DEPTH    = 4096;
  // Negedges from driving OE low to first valid data: sample edge + 1 + READ_LAT.
  localparam int EXP_K    = READ_LAT + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr;
  logic              oe, we, en;
  logic [DATA_W-1:0] tb_data;
  logic              tb_drive;
  wire  [DATA_W-1:0] ram_data;
  logic              busy, conflict;
`ifdef RAM2_RESP_STATS_EN
  logic [15:0]       rd_cnt, wr_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [ADDR_W-1:0] written [$];

  assign ram_data = tb_drive ? tb_data : {DATA_W{1'bz}};

  always #5 clk = ~clk;

  ram2_sram_responder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH_W  (DEPTH_W),
    .READ_LAT (READ_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ram_addr_i  (addr),
    .ram_data_io (ram_data),
    .ram_oe_i    (oe),
    .ram_we_i    (we),
    .ram_en_i    (en),
    .busy_o      (busy),
    .conflict_o  (conflict)
`ifdef RAM2_RESP_STATS_EN
    ,
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt)
`endif
  );

  // Undriven bus reads as Z in 4-state simulators and 0 in 2-state ones;
  // every value the DUT legitimately drives in this bench is nonzero.
  function automatic bit bus_idle();
    return (ram_data === {DATA_W{1'bz}}) || (ram_data === {DATA_W{1'b0}});
  endfunction

  function automatic int widx(input logic [ADDR_W-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int len);
    @(negedge clk);
    addr = a; tb_data = d; tb_drive = 1'b1; en = 1'b0; we = 1'b0;
    repeat (len) @(negedge clk);
    we = 1'b1; en = 1'b1; tb_drive = 1'b0;
    repeat (3) @(negedge clk);
    model[widx(a)] = d;
    written.push_back(a);
  endtask

  // Leaves OE/EN low; k = negedges until the bus first carries data (20 = timeout).
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output int k);
    @(negedge clk);
    addr = a; tb_drive = 1'b0; en = 1'b0; oe = 1'b0;
    d = '0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (!bus_idle()) begin
        d = ram_data;
        break;
      end
    end
  endtask

  task automatic end_read();
    oe = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = '0; oe = 1'b1; we = 1'b1; en = 1'b1; tb_data = '0; tb_drive = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b expected 0", conflict); end
    n_checks++; if (!bus_idle()) begin n_fail++; $display("FAIL reset_bus: got %h expected released", ram_data); end
`ifdef RAM2_RESP_STATS_EN
    n_checks++; if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: got rd=%0d wr=%0d expected 0 0", rd_cnt, wr_cnt); end
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] d;
    int k;
    @(negedge clk);
    addr = 18'h00010; tb_data = 16'hBEEF; tb_drive = 1'b1; en = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", busy); end
    we = 1'b1; en = 1'b1; tb_drive = 1'b0;
    repeat (3) @(negedge clk);
    model[widx(18'h00010)] = 16'hBEEF;
    written.push_back(18'h00010);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_idle: got %b expected 0", busy); end

    do_read(18'h00010, d, k);
    n_checks++; if (d !== 16'hBEEF) begin n_fail++; $display("FAIL read_data: got %h expected beef", d); end
    n_checks++; if (k != EXP_K) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", k, EXP_K); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b expected 1", busy); end
    #2 oe = 1'b1;
    #1;
    n_checks++; if (!bus_idle()) begin n_fail++; $display("FAIL read_release: got %h expected released", ram_data); end
    end_read();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_idle: got %b expected 0", busy); end
  endtask

  task automatic test_long_we();
    logic [DATA_W-1:0] d;
    int k;
`ifdef RAM2_RESP_STATS_EN
    logic [15:0] wr0, rd0;
    wr0 = wr_cnt;
`endif
    @(negedge clk);
    addr = 18'h00020; tb_data = 16'h1111; tb_drive = 1'b1; en = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);
    tb_data = 16'h2222;
    repeat (3) @(negedge clk);
    we = 1'b1; en = 1'b1; tb_drive = 1'b0;
    repeat (3) @(negedge clk);
    model[widx(18'h00020)] = 16'h2222;
    written.push_back(18'h00020);
`ifdef RAM2_RESP_STATS_EN
    n_checks++; if (wr_cnt - wr0 !== 16'd1) begin
      n_fail++; $display("FAIL long_we_wr_cnt: got %0d expected 1", wr_cnt - wr0); end
    rd0 = rd_cnt;
`endif
    do_read(18'h00020, d, k);
    n_checks++; if (d !== 16'h2222) begin n_fail++; $display("FAIL long_we_data: got %h expected 2222", d); end
    end_read();
`ifdef RAM2_RESP_STATS_EN
    n_checks++; if (rd_cnt - rd0 !== 16'd1) begin
      n_fail++; $display("FAIL long_we_rd_cnt: got %0d expected 1", rd_cnt - rd0); end
`endif
  endtask

  task automatic test_alias();
    logic [DATA_W-1:0] d;
    int k;
    do_write(18'h01005, 16'hA5A5, 2);
    do_read(18'h00005, d, k);
    n_checks++; if (d !== 16'hA5A5) begin n_fail++; $display("FAIL alias_5: got %h expected a5a5", d); end
    end_read();
    do_write(18'h3F000, 16'h5A3C, 1);
    do_read(18'h00000, d, k);
    n_checks++; if (d !== 16'h5A3C) begin n_fail++; $display("FAIL alias_0: got %h expected 5a3c", d); end
    end_read();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, exp_d;
    int k;
    for (int i = 0; i < 40; i++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = ADDR_W'($urandom);
        d = DATA_W'($urandom_range(1, 65535));
        do_write(a, d, int'($urandom_range(1, 5)));
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        a = {6'($urandom), a[11:0]};
        exp_d = model[widx(a)];
        do_read(a, d, k);
        n_checks++; if (d !== exp_d || k != EXP_K) begin
          n_fail++;
          $display("FAIL random_read @%h: got %h lat %0d expected %h lat %0d", a, d, k, exp_d, EXP_K);
        end
        end_read();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    int k;
    do_write(18'h00200, 16'h1357, 1);
    do_write(18'h00300, 16'h2468, 1);
    do_read(18'h00200, d, k);
    n_checks++; if (d !== 16'h1357) begin n_fail++; $display("FAIL b2b_first: got %h expected 1357", d); end
    addr = 18'h00300;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (ram_data === 16'h2468) break;
    end
    n_checks++; if (k != EXP_K) begin
      n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d (bus %h)", k, EXP_K, ram_data); end
    end_read();
  endtask

  task automatic test_reset_mid_write();
    logic [DATA_W-1:0] d;
    int k;
    do_write(18'h00777, 16'hC3C3, 1);
    @(negedge clk);
    addr = 18'h00777; tb_data = 16'h0F0F; tb_drive = 1'b1; en = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midwr_busy: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midwr_async_reset: got %b expected 0", busy); end
    we = 1'b1; en = 1'b1; tb_drive = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
`ifdef RAM2_RESP_STATS_EN
    n_checks++; if (wr_cnt !== 16'd0) begin n_fail++; $display("FAIL midwr_wr_cnt: got %0d expected 0", wr_cnt); end
`endif
    do_read(18'h00777, d, k);
    n_checks++; if (d !== model[widx(18'h00777)]) begin
      n_fail++; $display("FAIL midwr_prior: got %h expected %h", d, model[widx(18'h00777)]); end
    end_read();
  endtask

  task automatic test_conflict();
    logic [DATA_W-1:0] d;
    int k;
    n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_pre: got %b expected 0", conflict); end
    // Conflict raised while a read is driving the bus.
    do_read(18'h00777, d, k);
    n_checks++; if (d !== 16'hC3C3) begin n_fail++; $display("FAIL conflict_read: got %h expected c3c3", d); end
    #2 we = 1'b0;
    #1;
    n_checks++; if (!bus_idle()) begin n_fail++; $display("FAIL conflict_rd_release: got %h expected released", ram_data); end
    repeat (2) @(negedge clk);
    n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_rd_flag: got %b expected 1", conflict); end
    n_checks++; if (!bus_idle()) begin n_fail++; $display("FAIL conflict_rd_bus: got %h expected released", ram_data); end
    we = 1'b1; oe = 1'b1; en = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (conflict !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL conflict_sticky: got conflict=%b busy=%b expected 1 0", conflict, busy); end
    model[widx(18'h00777)] = 'x;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_clear: got %b expected 0", conflict); end

    // Conflict raised straight from idle.
    addr = 18'h00200; oe = 1'b0; we = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (!bus_idle()) begin n_fail++; $display("FAIL conflict_idle_bus[%0d]: got %h expected released", i, ram_data); end
    end
    n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_idle_flag: got %b expected 1", conflict); end
    oe = 1'b1; we = 1'b1; en = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_idle_sticky: got %b expected 1", conflict); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_long_we();
    test_alias();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    test_conflict();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
